// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: two writeback requesters in, register-file write port and status out
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [ADDR_W-1:0]    req0_addr;
    logic [DATA_W-1:0]    req0_data;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [ADDR_W-1:0]    req1_addr;
    logic [DATA_W-1:0]    req1_data;
    logic                 we3;
    logic [ADDR_W-1:0]    a3;
    logic [DATA_W-1:0]    wd3;
    logic [2**ADDR_W-1:0] pend_mask;
    logic                 idle;
    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready, we3, a3, wd3, pend_mask, idle
    );
    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, we3, a3, wd3, pend_mask, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the register-file write port between two held requesters
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int X0_DISCARD = 1
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int NREG = 2**ADDR_W;
    logic              r_hold0_v, r_hold1_v, r_rr, r_we3;
    logic [ADDR_W-1:0] r_hold0_a, r_hold1_a, r_a3;
    logic [DATA_W-1:0] r_hold0_d, r_hold1_d, r_wd3;
    logic              w_g0, w_g1, w_gnt, w_drop, w_acc0, w_acc1;
    logic [ADDR_W-1:0] w_ga;
    logic [DATA_W-1:0] w_gd;
    logic [NREG-1:0]   w_pend;
    always_comb begin
        w_g0   = r_hold0_v & (!r_hold1_v | !r_rr);
        w_g1   = r_hold1_v & (!r_hold0_v | r_rr);
        w_gnt  = w_g0 | w_g1;
        w_ga   = w_g0 ? r_hold0_a : r_hold1_a;
        w_gd   = w_g0 ? r_hold0_d : r_hold1_d;
        w_drop = (X0_DISCARD != 0) && (w_ga == '0);
        w_acc0 = bus.req0_valid & bus.req0_ready;
        w_acc1 = bus.req1_valid & bus.req1_ready;
    end
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < NREG; i++)
            w_pend[i] = (r_hold0_v && r_hold0_a == ADDR_W'(i)) ||
                        (r_hold1_v && r_hold1_a == ADDR_W'(i)) ||
                        (r_we3 && r_a3 == ADDR_W'(i));
        if (X0_DISCARD != 0) w_pend[0] = 1'b0;
    end
    assign bus.req0_ready = !rst & (!r_hold0_v | w_g0);
    assign bus.req1_ready = !rst & (!r_hold1_v | w_g1);
    assign bus.we3        = r_we3;
    assign bus.a3         = r_a3;
    assign bus.wd3        = r_wd3;
    assign bus.pend_mask  = w_pend;
    assign bus.idle       = !r_hold0_v & !r_hold1_v & !r_we3;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold0_v <= 1'b0;
            r_hold1_v <= 1'b0;
            r_rr      <= 1'b0;
            r_we3     <= 1'b0;
            r_a3      <= '0;
            r_wd3     <= '0;
        end else begin
            if (w_acc0) begin
                r_hold0_v <= 1'b1;
                r_hold0_a <= bus.req0_addr;
                r_hold0_d <= bus.req0_data;
            end else if (w_g0) r_hold0_v <= 1'b0;
            if (w_acc1) begin
                r_hold1_v <= 1'b1;
                r_hold1_a <= bus.req1_addr;
                r_hold1_d <= bus.req1_data;
            end else if (w_g1) r_hold1_v <= 1'b0;
            if (w_gnt) r_rr <= w_g0;
            r_we3 <= w_gnt & !w_drop;
            if (w_gnt & !w_drop) begin
                r_a3  <= w_ga;
                r_wd3 <= w_gd;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with a write-order scoreboard for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];
    logic [4:0] a0[3] = '{5'd1, 5'd2, 5'd3};
    logic [4:0] a1[3] = '{5'd9, 5'd10, 5'd11};
    logic exp_r0[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic exp_r1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .X0_DISCARD(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    task automatic smp();
        @(negedge clk);
    endtask
    always @(negedge clk) begin
        if (bus.we3 === 1'b1) begin
            chk("sb_has_entry", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) chk("wb_write", 64'({bus.a3, bus.wd3}), 64'(exp_q.pop_front()));
        end
    end
    initial begin
        logic acc0, acc1;
        int i0, i1;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        nxt();
        nxt();
        smp();
        chk("rst_ready0", 64'(bus.req0_ready), 64'(0));
        chk("rst_ready1", 64'(bus.req1_ready), 64'(0));
        nxt();
        rst = 1'b0;
        smp();
        chk("idle_we3", 64'(bus.we3), 64'(0));
        chk("idle_a3", 64'(bus.a3), 64'(0));
        chk("idle_wd3", 64'(bus.wd3), 64'(0));
        chk("idle_pend", 64'(bus.pend_mask), 64'(0));
        chk("idle_ready0", 64'(bus.req0_ready), 64'(1));
        chk("idle_ready1", 64'(bus.req1_ready), 64'(1));
        chk("idle_idle", 64'(bus.idle), 64'(1));
        nxt();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd5;
        bus.req0_data  = 32'hDEADBEEF;
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        smp();
        chk("single_ready0", 64'(bus.req0_ready), 64'(1));
        nxt();
        bus.req0_valid = 1'b0;
        smp();
        chk("single_pend_held", 64'(bus.pend_mask), 64'(32'h20));
        chk("single_we3_early", 64'(bus.we3), 64'(0));
        nxt();
        smp();
        chk("single_we3", 64'(bus.we3), 64'(1));
        chk("single_pend_we3", 64'(bus.pend_mask), 64'(32'h20));
        nxt();
        smp();
        chk("single_we3_drop", 64'(bus.we3), 64'(0));
        chk("single_pend_clear", 64'(bus.pend_mask), 64'(0));
        chk("single_idle", 64'(bus.idle), 64'(1));
        nxt();
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 5'd0;
        bus.req1_data  = 32'd7;
        smp();
        chk("x0_ready1", 64'(bus.req1_ready), 64'(1));
        nxt();
        bus.req1_valid = 1'b0;
        smp();
        chk("x0_pend_held", 64'(bus.pend_mask), 64'(0));
        chk("x0_idle_held", 64'(bus.idle), 64'(0));
        nxt();
        smp();
        chk("x0_we3", 64'(bus.we3), 64'(0));
        chk("x0_pend", 64'(bus.pend_mask), 64'(0));
        chk("x0_idle", 64'(bus.idle), 64'(1));
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({a0[k], 32'h100 + 32'(a0[k])});
            exp_q.push_back({a1[k], 32'h100 + 32'(a1[k])});
        end
        i0 = 0;
        i1 = 0;
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int c = 0; c < 9; c++) begin
            nxt();
            if (acc0) i0++;
            if (acc1) i1++;
            bus.req0_valid = i0 < 3;
            bus.req0_addr  = i0 < 3 ? a0[i0] : 5'd0;
            bus.req0_data  = 32'h100 + 32'(bus.req0_addr);
            bus.req1_valid = i1 < 3;
            bus.req1_addr  = i1 < 3 ? a1[i1] : 5'd0;
            bus.req1_data  = 32'h100 + 32'(bus.req1_addr);
            smp();
            if (c < 5) begin
                chk($sformatf("rr_ready0_c%0d", c), 64'(bus.req0_ready), 64'(exp_r0[c]));
                chk($sformatf("rr_ready1_c%0d", c), 64'(bus.req1_ready), 64'(exp_r1[c]));
            end
            if (c >= 2 && c <= 7) chk($sformatf("rr_no_bubble_c%0d", c), 64'(bus.we3), 64'(1));
            acc0 = bus.req0_valid & bus.req0_ready;
            acc1 = bus.req1_valid & bus.req1_ready;
        end
        nxt();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd12;
        bus.req0_data  = 32'hA;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 5'd12;
        bus.req1_data  = 32'hB;
        exp_q.push_back({5'd12, 32'hA});
        exp_q.push_back({5'd12, 32'hB});
        smp();
        nxt();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            smp();
            chk($sformatf("same_pend12_c%0d", c), 64'(bus.pend_mask[12]), 64'(c < 4));
            if (c < 4) nxt();
        end
        nxt();
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'd20;
        bus.req0_data  = 32'h20;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 5'd21;
        bus.req1_data  = 32'h21;
        exp_q.push_back({5'd20, 32'h20});
        smp();
        nxt();
        bus.req0_addr  = 5'd22;
        bus.req0_data  = 32'h22;
        bus.req1_valid = 1'b0;
        smp();
        chk("pre_rst_ready0", 64'(bus.req0_ready), 64'(1));
        nxt();
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        smp();
        chk("pre_rst_pend", 64'(bus.pend_mask), 64'(32'h0070_0000));
        chk("pre_rst_idle", 64'(bus.idle), 64'(0));
        chk("in_rst_ready0", 64'(bus.req0_ready), 64'(0));
        nxt();
        rst = 1'b0;
        smp();
        chk("post_rst_we3", 64'(bus.we3), 64'(0));
        chk("post_rst_pend", 64'(bus.pend_mask), 64'(0));
        repeat (5) nxt();
        smp();
        chk("post_rst_idle", 64'(bus.idle), 64'(1));
        chk("sb_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
